// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and defaults common to tx and rx.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 217;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter; tick_o marks the last cycle of each bit.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  output logic tick_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] cnt_q;

  // Count down; restart on load or after reaching zero so every bit is CLKS_PER_BIT long.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= RELOAD;
    end else if (load_i || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, even parity, STOP_BITS stop bits.
// All outputs are registered; tx_out follows the state one clock later, so the
// start bit begins on the first edge after the accepting edge.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  uart_state_e          state_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 tx_out_q;
  logic                 tx_ready_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;
  logic                 tick;

  // Timer is held at full period while idle so START gets a full bit.
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load_i (state_q == ST_IDLE),
    .tick_o (tick)
  );

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tx_out_q <= 1'b1;
          if (tx_valid && tx_ready_q) begin
            shift_q    <= tx_data;
            par_q      <= even_parity(tx_data);
            state_q    <= ST_START;
            tx_ready_q <= 1'b0;
            tx_busy_q  <= 1'b1;
          end
        end
        ST_START: begin
          tx_out_q <= 1'b0;
          if (tick) begin
            state_q <= ST_DATA;
            idx_q   <= '0;
          end
        end
        ST_DATA: begin
          tx_out_q <= shift_q[idx_q];
          if (tick) begin
            if (idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= ST_PARITY;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          tx_out_q <= par_q;
          if (tick) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          tx_out_q <= 1'b1;
          if (tick) begin
            if (idx_q == 3'(STOP_BITS - 1)) begin
              state_q    <= ST_IDLE;
              idx_q      <= '0;
              tx_done_q  <= 1'b1;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          idx_q      <= '0;
          tx_out_q   <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: line waveform compared against a frame-bit model,
// plus a mid-bit sampling receiver for loopback checks.
module tb_uart_tx;

  localparam int N  = 217;
  localparam int SB = 1;
  localparam int FB = 10 + SB;
  localparam int FL = FB * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx #(.CLKS_PER_BIT(N), .STOP_BITS(SB)) dut (
    .clock    (clock),
    .reset    (reset),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic accept(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    chk("ready_before_accept", {31'd0, tx_ready}, 32'd1);
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  // Starts at the negedge after an accepting edge (k=0) and follows the frame
  // through k=FL. The expected line at sample k is frame bit (k-1)/N.
  task automatic watch(input logic [7:0] b, input bit hold, input logic [7:0] nb, input int inj_k);
    logic [FB-1:0] fr;
    logic [FB-1:0] samp;
    logic [7:0]    rxb;
    logic          rx_err;
    int            bad;
    int            done_k;
    fr     = '1;
    fr[0]  = 1'b0;
    fr[8:1] = b;
    fr[9]  = ^b;
    samp   = '0;
    bad    = 0;
    done_k = -1;
    chk("line_idle_k0", {31'd0, tx_out}, 32'd1);
    chk("ready_low_k0", {31'd0, tx_ready}, 32'd0);
    chk("busy_high_k0", {31'd0, tx_busy}, 32'd1);
    for (int k = 1; k <= FL; k++) begin
      @(negedge clock);
      if (tx_out !== fr[(k-1)/N]) bad++;
      if (tx_ready !== (k == FL)) bad++;
      if (tx_busy !== (k != FL)) bad++;
      if (tx_done === 1'b1) begin
        if (done_k < 0) done_k = k; else bad++;
      end
      if (((k - 1) % N) == N / 2) samp[(k-1)/N] = tx_out;
      if (hold) begin
        tx_valid = 1'b1;
        tx_data  = nb;
      end else if (k == inj_k) begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
      end else begin
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
      end
    end
    chk("frame_waveform_mismatches", bad, 0);
    chk("done_latency", done_k, FL);
    rxb    = samp[8:1];
    rx_err = samp[0] | (samp[9] ^ (^samp[8:1])) | ~(&samp[FB-1:10]);
    chk("loopback_byte", {24'd0, rxb}, {24'd0, b});
    chk("loopback_err", {31'd0, rx_err}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int s1, s2, bad;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (2) @(negedge clock);
    chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    repeat (2) @(negedge clock);
    chk("no_accept_in_reset", {31'd0, tx_busy}, 32'd0);
    tx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_after_reset", {31'd0, tx_busy}, 32'd0);

    // Directed bytes: 0x55 pattern, odd parity 0x07, all-zero 0x00.
    accept(8'h55); watch(8'h55, 1'b0, 8'h00, 0);
    @(negedge clock);
    accept(8'h07); watch(8'h07, 1'b0, 8'h00, 0);
    @(negedge clock);
    accept(8'h00); watch(8'h00, 1'b0, 8'h00, 0);
    @(negedge clock);

    // Back-to-back with tx_valid held high.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    chk("ready_before_b2b", {31'd0, tx_ready}, 32'd1);
    @(negedge clock);
    s1 = cyc;
    watch(8'hA5, 1'b1, 8'h3C, 0);
    @(negedge clock);
    s2 = cyc;
    chk("b2b_accept_spacing", s2 - s1, FL + 1);
    watch(8'h3C, 1'b0, 8'h00, 0);
    bad = 0;
    repeat (N + 5) begin
      @(negedge clock);
      if (tx_busy !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    chk("no_duplicate_frame", bad, 0);

    // 0xFF offered mid-frame while not ready must be ignored.
    b = 8'($urandom);
    accept(b); watch(b, 1'b0, 8'h00, 3 * N + 17);
    bad = 0;
    repeat (N + 5) begin
      @(negedge clock);
      if (tx_busy !== 1'b0) bad++;
    end
    chk("ignored_mid_frame_byte", bad, 0);

    // Reset during data bit 4 of 0xC3.
    accept(8'hC3);
    repeat (5 * N + N / 2) @(negedge clock);
    chk("c3_bit4_on_line", {31'd0, tx_out}, 32'd0);
    chk("c3_busy_before_reset", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset_tx_out", {31'd0, tx_out}, 32'd1);
    chk("midreset_busy", {31'd0, tx_busy}, 32'd0);
    chk("midreset_ready", {31'd0, tx_ready}, 32'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (tx_done !== 1'b0) bad++;
    end
    reset = 1'b0;
    repeat (2 * N) begin
      @(negedge clock);
      if (tx_done !== 1'b0 || tx_out !== 1'b1) bad++;
    end
    chk("midreset_no_done", bad, 0);
    accept(8'h12); watch(8'h12, 1'b0, 8'h00, 0);
    @(negedge clock);

    // Loopback bytes.
    accept(8'h00); watch(8'h00, 1'b0, 8'h00, 0);
    @(negedge clock);
    accept(8'hFF); watch(8'hFF, 1'b0, 8'h00, 0);
    @(negedge clock);
    accept(8'h81); watch(8'h81, 1'b0, 8'h00, 0);

    // Random bytes with random idle gaps.
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clock);
      b = 8'($urandom);
      accept(b);
      watch(b, 1'b0, 8'h00, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
